y86_imem_loader: RTL and testbench
==================================

# y86_imem_loader

Byte-addressed instruction memory with a streaming write-side loader for the sequential Y86-64 core. A host pushes a framed program image (base address, length, payload) over a valid/ready byte stream. The block writes the payload into memory and reports done or error. It also supplies the combinational 10-byte instruction window that the fetch stage reads at PC.

## Interface
- `MEM_BYTES`, default 1024: memory size in bytes.
- `ADDR_W`, default 10: internal byte address width, equal to clog2(MEM_BYTES).
- Reset is asynchronous and active-low. The design uses one clock.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse that begins a new frame from any state.
- `in_valid`  in  1  a stream byte is present.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  the block accepts a byte this cycle.
- `busy`  out  1  a frame is in progress (HDR_ADDR, HDR_LEN or PAYLOAD).
- `done`  out  1  the last frame completed successfully; level signal.
- `err`  out  1  the last frame was rejected; level signal.
- `rd_pc`  in  64  fetch address.
- `rd_bytes`  out  80  mem[rd_pc+0..9], little-endian: byte i sits in bits [8i+7:8i].
- `rd_oob`  out  1  at least one byte of the 10-byte window is at or beyond MEM_BYTES.

## Operation
- Frame format:
  - 8 bytes of base address, little-endian.
  - 2 bytes of length N, little-endian.
  - N payload bytes.
- A beat is transferred when `in_valid` and `in_ready` are both high at a rising edge.
- States and transitions:
  - IDLE: `in_ready`=0. `start` moves to HDR_ADDR.
  - HDR_ADDR: `in_ready`=1. Shifts the 8 address bytes into `base` (byte k goes to bits [8k+7:8k]), counting with a 4-bit counter. After the 8th beat, moves to HDR_LEN.
  - HDR_LEN: `in_ready`=1. Collects 2 bytes into `len`. On the 2nd beat the block evaluates the full 64-bit unsigned value base + N (the new len byte included):
    - If base + N > MEM_BYTES, go to ERR.
    - Else if N == 0, go to DONE.
    - Else go to PAYLOAD with `cnt` = 0.
  - PAYLOAD: `in_ready`=1. Each beat writes mem[base[ADDR_W-1:0] + cnt] <= in_data, then cnt++ (16-bit). The beat where cnt == N-1 moves to DONE.
  - DONE: `done`=1, `in_ready`=0. Stays until `start`.
  - ERR: `err`=1, `in_ready`=0. No memory write happens for a rejected frame. Stays until `start`.
- `start` takes priority in every state. The next state is HDR_ADDR and the counters clear.
  - A beat presented in the same cycle as `start` is not accepted, because `in_ready` depends only on state.
  - Bytes already written by an aborted frame stay in memory.
- Beats offered in IDLE, DONE or ERR are ignored. No transfer occurs because `in_ready`=0.
- Read port is combinational:
  - rd_bytes byte i = mem[rd_pc+i] when rd_pc+i < MEM_BYTES, otherwise 8'h00.
  - `rd_oob` = (rd_pc > MEM_BYTES-10), compared on the full 64 bits.
  - The read reflects a write from the following delta after that write's clock edge.
- Memory contents are not reset and survive `rst_n`. Only the FSM, counters, `base` and `len` reset.

## Timing
- Reset values: state IDLE, `in_ready`=0, `busy`=0, `done`=0, `err`=0, base=len=cnt=0.
- Reset mid-frame: the FSM aborts to IDLE immediately. Partial writes remain in memory.
- All outputs except `rd_bytes` and `rd_oob` are Moore outputs decoded from registered state.
- Latency:
  - `start` at edge t gives `in_ready`=1 after t.
  - At one beat per cycle, a frame of N bytes reaches DONE 10+N edges after the first accepted beat.
  - N=0 reaches DONE after the 10th beat.
- Stalls: `in_valid` low holds every counter. Throughput is one byte per cycle, with no bubbles.
- Memory write occurs at the same edge that accepts the payload beat.

## Test plan
- Load the frame base=19, N=10, payload 30 F3 0A 00 00 00 00 00 00 00 (irmovq $10,%rbx) with no stalls.
  - done=1 exactly 20 edges after the first beat.
  - With rd_pc=19: rd_bytes = 80'h0000_0000_0000_000A_F330 and rd_oob=0.
- Same frame with in_valid toggling 1/0 every cycle:
  - identical memory result;
  - done arrives after 39 edges;
  - busy stays high throughout.
- Frame with base=1020 and N=8 (overflow):
  - err=1 after the 10th beat and in_ready=0;
  - mem[1020..1023] unchanged.
- Frame with N=0: done=1 after 10 beats and no memory change.
- Abort case: start, 8 address beats (base=0), len N=4, 2 payload beats AA BB, then a `start` pulse held together with in_valid.
  - The beat in the `start` cycle is not accepted.
  - mem[0..1] = AA, BB.
  - The new frame loads correctly.
- Reset mid-payload (assert rst_n=0 between edges):
  - in_ready, busy, done and err all drop to 0 immediately;
  - already-written bytes read back intact;
  - rd_pc=1016 gives rd_oob=1 and zero-filled upper bytes.

Source files
------------

// File: rtl/y86_imem_loader.sv
// Purpose: byte-addressed Y86-64 instruction memory, loaded by a framed byte stream, with a 10-byte fetch window.
// Latency: one beat per cycle; DONE is reached 10+N edges after the first beat. The read port is combinational.
// Backpressure: in_ready is high only in HDR_ADDR, HDR_LEN and PAYLOAD. In_valid low holds every counter.
module y86_imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [63:0] rd_pc,
  output logic [79:0] rd_bytes,
  output logic        rd_oob
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_ADDR, S_HDR_LEN, S_PAYLOAD, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    hcnt, hcnt_nxt;
  logic [63:0]   base, base_nxt;
  logic [15:0]   len, len_nxt;
  logic [15:0]   cnt, cnt_nxt;
  logic          beat;
  logic          wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]   len_full;
  logic [64:0]   end_addr;
  logic [64:0]   rd_addr;

  logic [7:0] mem [MEM_BYTES];

  // in_ready is decoded from state only, so a start cycle never accepts a beat
  assign in_ready = (state == S_HDR_ADDR) || (state == S_HDR_LEN) || (state == S_PAYLOAD);
  assign busy     = in_ready;
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
  assign beat     = in_valid && in_ready;

  // Length including the byte arriving now. The bounds check uses 65 bits so that base+N cannot wrap.
  assign len_full = {in_data, len[7:0]};
  assign end_addr = {1'b0, base} + {49'd0, len_full};
  assign wr_addr  = base[ADDR_W-1:0] + cnt[ADDR_W-1:0];

  // Register FSM state, header fields and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      hcnt  <= '0;
      base  <= '0;
      len   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      base  <= base_nxt;
      len   <= len_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: parse the frame header, then stream the payload into memory. Start overrides every state.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    base_nxt  = base;
    len_nxt   = len;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    if (start) begin
      state_nxt = S_HDR_ADDR;
      hcnt_nxt  = '0;
      len_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_HDR_ADDR: if (beat) begin
          base_nxt[{hcnt[2:0], 3'b000} +: 8] = in_data;
          hcnt_nxt = hcnt + 4'd1;
          if (hcnt == 4'd7) state_nxt = S_HDR_LEN;
        end
        S_HDR_LEN: if (beat) begin
          hcnt_nxt = hcnt + 4'd1;
          if (hcnt == 4'd8) begin
            len_nxt[7:0] = in_data;
          end else begin
            len_nxt = len_full;
            cnt_nxt = '0;
            if (end_addr > 65'(MEM_BYTES)) state_nxt = S_ERR;
            else if (len_full == 16'd0)    state_nxt = S_DONE;
            else                           state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (beat) begin
          wr_en   = 1'b1;
          cnt_nxt = cnt + 16'd1;
          if (cnt == len - 16'd1) state_nxt = S_DONE;
        end
        default: ;
      endcase
    end
  end

  // Memory array. It has no reset, so a program image survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
  end

  // Fetch window. Bytes past the end of memory read as zero.
  always_comb begin
    rd_bytes = '0;
    rd_addr  = '0;
    for (int i = 0; i < 10; i++) begin
      rd_addr = {1'b0, rd_pc} + 65'(i);
      if (rd_addr < 65'(MEM_BYTES)) rd_bytes[8*i +: 8] = mem[rd_addr[ADDR_W-1:0]];
    end
  end

  assign rd_oob = rd_pc > 64'(MEM_BYTES - 10);

endmodule

// File: tb/tb_y86_imem_loader.sv
module tb_y86_imem_loader;
  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, busy, done, err, rd_oob;
  logic [63:0] rd_pc = 64'd0;
  logic [79:0] rd_bytes;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [MB];
  logic [7:0] stream [$];

  y86_imem_loader #(.MEM_BYTES(MB), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .err(err),
    .rd_pc(rd_pc), .rd_bytes(rd_bytes), .rd_oob(rd_oob)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference window: ten bytes from the model memory, with zero fill past the end
  function automatic logic [79:0] exp_window(input logic [63:0] pc);
    logic [79:0] w;
    logic [64:0] a;
    w = '0;
    for (int i = 0; i < 10; i++) begin
      a = {1'b0, pc} + 65'(i);
      if (a < 65'(MB)) w[8*i +: 8] = ref_mem[a[9:0]];
    end
    return w;
  endfunction

  task automatic build_frame(input logic [63:0] b, input int n);
    stream.delete();
    for (int k = 0; k < 8; k++) stream.push_back(b[8*k +: 8]);
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int k = 0; k < n; k++) stream.push_back(8'($urandom));
  endtask

  task automatic apply_model(input int b, input int n);
    for (int k = 0; k < n; k++) ref_mem[b + k] = stream[10 + k];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive stream[0..nbytes-1]. Mode 0 drives every cycle, mode 1 toggles valid, mode 2 drives randomly.
  // Returns the number of edges from the first accepted beat to the last accepted beat, both included.
  task automatic send(input int nbytes, input int mode, output int edges);
    int i = 0, cyc = 0, first = -1, last = -1, idle = 0;
    bit v, rdy, busy_ok;
    busy_ok = 1'b1;
    while (i < nbytes && idle < 64) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_data  = stream[i];
      rdy      = in_ready;
      @(posedge clk);
      cyc++;
      if (v && rdy) begin
        if (first < 0) first = cyc;
        last = cyc;
        i++;
        idle = 0;
      end else begin
        idle++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    edges = last - first + 1;
    total++;
    if (i != nbytes || !busy_ok) begin
      bad++;
      $display("FAIL send: accepted=%0d required=%0d busy_held=%0d required=1", i, nbytes, busy_ok);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready, busy, done, err} !== 4'b0000) begin
      bad++; $display("FAIL reset_outputs: got %b required 0000", {in_ready, busy, done, err});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'h55;
    end
    @(negedge clk); in_valid = 1'b0;
    total++;
    if ({in_ready, busy, done, err} !== 4'b0000) begin
      bad++; $display("FAIL idle_ignores_beats: got %b required 0000", {in_ready, busy, done, err});
    end
    rd_pc = 64'd1014; #1;
    total++;
    if (rd_oob !== 1'b0) begin bad++; $display("FAIL oob_1014: got %b required 0", rd_oob); end
    rd_pc = 64'd1015; #1;
    total++;
    if (rd_oob !== 1'b1) begin bad++; $display("FAIL oob_1015: got %b required 1", rd_oob); end
  endtask

  task automatic test_fill();
    int e;
    pulse_start();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL start_latency: in_ready=%b required 1", in_ready); end
    build_frame(64'd0, MB);
    send(10 + MB, 0, e);
    total++;
    if (done !== 1'b1 || err !== 1'b0 || e != 10 + MB) begin
      bad++; $display("FAIL fill_done: done=%b err=%b edges=%0d required 1 0 %0d", done, err, e, 10 + MB);
    end
    apply_model(0, MB);
    for (int pc = 0; pc < MB; pc += 10) begin
      rd_pc = 64'(pc); #1;
      total++;
      if (rd_bytes !== exp_window(rd_pc)) begin
        bad++; $display("FAIL fill_mem pc=%0d: got %h required %h", pc, rd_bytes, exp_window(rd_pc));
      end
    end
  endtask

  task automatic load_irmovq(input int mode, output int e);
    build_frame(64'd19, 10);
    stream[10] = 8'h30; stream[11] = 8'hF3; stream[12] = 8'h0A;
    for (int k = 13; k < 20; k++) stream[k] = 8'h00;
    pulse_start();
    send(20, mode, e);
  endtask

  task automatic test_irmovq();
    int e;
    load_irmovq(0, e);
    total++;
    if (e != 20 || done !== 1'b1) begin
      bad++; $display("FAIL irmovq_latency: edges=%0d done=%b required 20 1", e, done);
    end
    apply_model(19, 10);
    rd_pc = 64'd19; #1;
    total++;
    if (rd_bytes !== 80'h0000_0000_0000_000A_F330 || rd_oob !== 1'b0) begin
      bad++; $display("FAIL irmovq_window: got %h oob=%b required 0000000000000000af330 0", rd_bytes, rd_oob);
    end
  endtask

  task automatic test_stall_toggle();
    int e;
    pulse_start();
    build_frame(64'd19, 10);
    send(20, 0, e);
    apply_model(19, 10);
    load_irmovq(1, e);
    apply_model(19, 10);
    total++;
    if (e != 39 || done !== 1'b1) begin
      bad++; $display("FAIL toggle_latency: edges=%0d done=%b required 39 1", e, done);
    end
    rd_pc = 64'd19; #1;
    total++;
    if (rd_bytes !== 80'h0000_0000_0000_000A_F330) begin
      bad++; $display("FAIL toggle_window: got %h required 0000000000000000af330", rd_bytes);
    end
  endtask

  task automatic test_overflow();
    int e;
    pulse_start();
    build_frame(64'd1020, 8);
    for (int k = 0; k < 4; k++) stream[10 + k] = ~ref_mem[1020 + k];
    send(10, 0, e);
    total++;
    if (err !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL overflow_err: err=%b in_ready=%b done=%b required 1 0 0", err, in_ready, done);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); in_valid = 1'b1; in_data = stream[10 + k];
    end
    @(negedge clk); in_valid = 1'b0;
    for (int pc = 1014; pc <= 1020; pc += 6) begin
      rd_pc = 64'(pc); #1;
      total++;
      if (rd_bytes !== exp_window(rd_pc)) begin
        bad++; $display("FAIL overflow_mem pc=%0d: got %h required %h", pc, rd_bytes, exp_window(rd_pc));
      end
    end
  endtask

  task automatic test_boundaries();
    int e, b;
    b = $urandom_range(0, MB - 10);
    pulse_start();
    build_frame(64'(b), 0);
    send(10, 0, e);
    total++;
    if (done !== 1'b1 || e != 10) begin
      bad++; $display("FAIL zero_len: done=%b edges=%0d required 1 10", done, e);
    end
    rd_pc = 64'(b); #1;
    total++;
    if (rd_bytes !== exp_window(rd_pc)) begin
      bad++; $display("FAIL zero_len_mem: got %h required %h", rd_bytes, exp_window(rd_pc));
    end
    pulse_start();
    build_frame(64'd1024, 0);
    send(10, 2, e);
    total++;
    if (done !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL base_at_end_len0: done=%b err=%b required 1 0", done, err);
    end
    pulse_start();
    build_frame(64'd1016, 8);
    send(18, 2, e);
    apply_model(1016, 8);
    rd_pc = 64'd1016; #1;
    total++;
    if (done !== 1'b1 || rd_bytes !== exp_window(rd_pc)) begin
      bad++; $display("FAIL exact_fit: done=%b got %h required 1 %h", done, rd_bytes, exp_window(rd_pc));
    end
  endtask

  task automatic test_abort();
    int e, b, n;
    pulse_start();
    build_frame(64'd0, 4);
    stream[10] = 8'hAA; stream[11] = 8'hBB; stream[12] = 8'hCC; stream[13] = 8'hDD;
    send(12, 0, e);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    ref_mem[0] = 8'hAA; ref_mem[1] = 8'hBB;
    total++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL abort_restart: in_ready=%b done=%b required 1 0", in_ready, done);
    end
    rd_pc = 64'd0; #1;
    total++;
    if (rd_bytes !== exp_window(rd_pc)) begin
      bad++; $display("FAIL abort_partial: got %h required %h", rd_bytes, exp_window(rd_pc));
    end
    b = $urandom_range(0, 1000);
    n = $urandom_range(1, 20);
    build_frame(64'(b), n);
    send(10 + n, 2, e);
    apply_model(b, n);
    for (int pc = b; pc < b + n; pc += 10) begin
      rd_pc = 64'(pc); #1;
      total++;
      if (done !== 1'b1 || rd_bytes !== exp_window(rd_pc)) begin
        bad++; $display("FAIL abort_reload pc=%0d: done=%b got %h required 1 %h", pc, done, rd_bytes, exp_window(rd_pc));
      end
    end
  endtask

  task automatic test_random();
    int e, b, n;
    for (int it = 0; it < 10; it++) begin
      b = $urandom_range(0, 1030);
      n = $urandom_range(0, 30);
      pulse_start();
      build_frame(64'(b), n);
      if (b + n > MB) begin
        send(10, 2, e);
        total++;
        if (err !== 1'b1 || done !== 1'b0) begin
          bad++; $display("FAIL rand_ovf base=%0d n=%0d: err=%b done=%b required 1 0", b, n, err, done);
        end
      end else begin
        send(10 + n, 2, e);
        apply_model(b, n);
        total++;
        if (done !== 1'b1 || err !== 1'b0) begin
          bad++; $display("FAIL rand_ok base=%0d n=%0d: done=%b err=%b required 1 0", b, n, done, err);
        end
      end
    end
    for (int pc = 0; pc < MB; pc += 10) begin
      rd_pc = 64'(pc); #1;
      total++;
      if (rd_bytes !== exp_window(rd_pc)) begin
        bad++; $display("FAIL rand_mem pc=%0d: got %h required %h", pc, rd_bytes, exp_window(rd_pc));
      end
    end
  endtask

  task automatic test_reset_mid();
    int e;
    pulse_start();
    build_frame(64'd1000, 20);
    send(22, 0, e);
    apply_model(1000, 12);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, busy, done, err} !== 4'b0000) begin
      bad++; $display("FAIL reset_mid: got %b required 0000", {in_ready, busy, done, err});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int pc = 1000; pc <= 1010; pc += 10) begin
      rd_pc = 64'(pc); #1;
      total++;
      if (rd_bytes !== exp_window(rd_pc)) begin
        bad++; $display("FAIL reset_keep pc=%0d: got %h required %h", pc, rd_bytes, exp_window(rd_pc));
      end
    end
    rd_pc = 64'd1016; #1;
    total++;
    if (rd_oob !== 1'b1 || rd_bytes[79:64] !== 16'h0000 || rd_bytes !== exp_window(rd_pc)) begin
      bad++; $display("FAIL reset_oob: oob=%b got %h required 1 %h", rd_oob, rd_bytes, exp_window(rd_pc));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_fill();
    test_irmovq();
    test_stall_toggle();
    test_overflow();
    test_boundaries();
    test_abort();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
